// File: rtl/mux_b_pipe.sv
// mux_b_pipe: ALU B-operand selector feeding a valid/ready register stage with a one-entry skid buffer.
// The skid entry absorbs the operand accepted in the cycle the consumer stalls, so in_ready never depends on out_ready.
module mux_b_pipe #(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int SHIFT     = 2,
    parameter int CONST_VAL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mux_b_control,
    input  logic             zext,
    input  logic [WIDTH-1:0] regB_out,
    input  logic [IMM_W-1:0] imm_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mux_b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);
    logic [WIDTH-1:0] ext;
    logic [WIDTH-1:0] sel_data;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;

    always_comb begin
        ext      = zext ? WIDTH'(imm_in) : WIDTH'($signed(imm_in));
        sel_data = mux_b_control == 2'b00 ? regB_out :
                   mux_b_control == 2'b01 ? WIDTH'(CONST_VAL) :
                   mux_b_control == 2'b10 ? ext : ext << SHIFT;
    end

    assign in_ready  = !skid_valid_q && reset;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_valid_q && out_ready;
    assign mux_b_out = main_data_q;
    assign out_valid = main_valid_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q) begin
            if (in_xfer) begin
                main_data_d  = sel_data;
                main_valid_d = 1'b1;
            end
        end else if (out_xfer) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_data_d = sel_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_data_d  = sel_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end
endmodule

// File: tb/tb_mux_b_pipe.sv
// tb_mux_b_pipe: directed vector table, backpressure/streaming/reset sequences and a random FIFO-model run.
module tb_mux_b_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mux_b_control = 2'b00;
    logic        zext = 1'b0;
    logic [31:0] regB_out = '0;
    logic [15:0] imm_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] mux_b_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;

    mux_b_pipe dut (
        .clk(clk), .reset(reset), .mux_b_control(mux_b_control), .zext(zext),
        .regB_out(regB_out), .imm_in(imm_in), .in_valid(in_valid), .in_ready(in_ready),
        .mux_b_out(mux_b_out), .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        zx;
        logic [31:0] rb;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_sel(input logic [1:0] s, input logic zx,
                                              input logic [31:0] rb, input logic [15:0] imm);
        logic [31:0] e;
        e = zx ? {16'h0000, imm} : {{16{imm[15]}}, imm};
        if (s == 2'b00) return rb;
        if (s == 2'b01) return 32'd4;
        if (s == 2'b10) return e;
        return {e[29:0], 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] s, input logic zx, input logic [31:0] rb, input logic [15:0] imm);
        mux_b_control = s;
        zext = zx;
        regB_out = rb;
        imm_in = imm;
        in_valid = 1'b1;
    endtask

    vec_t vecs[7];
    logic [31:0] q[$];
    logic [31:0] prev_out;
    logic        prev_stall;
    logic        exp_rdy;
    logic        exp_vld;

    initial begin
        vecs[0] = '{2'b00, 1'b0, 32'hDEADBEEF, 16'h0000, 32'hDEADBEEF};
        vecs[1] = '{2'b01, 1'b0, 32'h12345678, 16'h0000, 32'h00000004};
        vecs[2] = '{2'b10, 1'b0, 32'h0,        16'h8001, 32'hFFFF8001};
        vecs[3] = '{2'b11, 1'b0, 32'h0,        16'h8001, 32'hFFFE0004};
        vecs[4] = '{2'b10, 1'b1, 32'h0,        16'h8001, 32'h00008001};
        vecs[5] = '{2'b11, 1'b1, 32'h0,        16'hFFFF, 32'h0003FFFC};
        vecs[6] = '{2'b11, 1'b0, 32'h0,        16'h7FFF, 32'h0001FFFC};

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mux_b_out", mux_b_out, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        @(posedge clk);
        #6 reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].sel, vecs[i].zx, vecs[i].rb, vecs[i].imm);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), mux_b_out, vecs[i].exp);
            chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_occ", 32'(occupancy), 32'd0);

        out_ready = 1'b0;
        issue(2'b00, 1'b0, 32'h11, 16'h0);
        step();
        chk("bp_occ1", 32'(occupancy), 32'd1);
        issue(2'b00, 1'b0, 32'h22, 16'h0);
        step();
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out", mux_b_out, 32'h11);
        issue(2'b00, 1'b0, 32'h99, 16'h0);
        step();
        chk("bp_hold_out", mux_b_out, 32'h11);
        chk("bp_hold_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_second", mux_b_out, 32'h22);
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_empty_occ", 32'(occupancy), 32'd0);
        chk("bp_empty_ready", 32'(in_ready), 32'd1);
        chk("bp_empty_valid", 32'(out_valid), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            issue(2'b00, 1'b0, 32'(i), 16'h0);
            step();
            chk($sformatf("stream%0d_data", i), mux_b_out, 32'(i));
            chk($sformatf("stream%0d_occ", i), 32'(occupancy), 32'd1);
            chk($sformatf("stream%0d_rdy", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();

        out_ready = 1'b0;
        issue(2'b00, 1'b0, 32'h11, 16'h0);
        step();
        issue(2'b00, 1'b0, 32'h22, 16'h0);
        step();
        in_valid = 1'b0;
        chk("rs_occ2", 32'(occupancy), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_data", mux_b_out, 32'd0);
        chk("rs_occ", 32'(occupancy), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rs_ready_after", 32'(in_ready), 32'd1);
        chk("rs_no_stale", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        issue(2'b00, 1'b0, 32'h55, 16'h0);
        step();
        chk("rs_new_data", mux_b_out, 32'h55);
        chk("rs_new_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0;
        step();
        chk("rs_after_valid", 32'(out_valid), 32'd0);

        q.delete();
        prev_stall = 1'b0;
        prev_out = '0;
        for (int c = 0; c < 1000; c++) begin
            mux_b_control = 2'($urandom_range(0, 3));
            zext = 1'($urandom_range(0, 1));
            regB_out = $urandom;
            imm_in = 16'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            exp_rdy = (q.size() < 2);
            exp_vld = (q.size() > 0);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rnd_out_valid", 32'(out_valid), 32'(exp_vld));
            chk("rnd_occ", 32'(occupancy), 32'(q.size()));
            if (exp_vld) chk("rnd_data", mux_b_out, q[0]);
            if (prev_stall) chk("rnd_stable", mux_b_out, prev_out);
            prev_stall = exp_vld && !out_ready;
            prev_out = mux_b_out;
            @(posedge clk);
            if (exp_vld && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) q.push_back(model_sel(mux_b_control, zext, regB_out, imm_in));
            #1;
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mux_b_pipe.md
Name: mux_b_pipe

Overview:
- Parametrised, registered successor to the ALU B-operand selector.
- Selects the ALU B operand from four sources: register B, a constant, an extended immediate, or an extended and left-shifted immediate.
- The selected operand passes through a valid/ready register stage with a one-entry skid buffer. This allows the datapath to stall the ALU without losing an issued operand.
- Sits between the register file / immediate extraction and the ALU B input.

Parameters:
- WIDTH, 32, operand width in bits; must be >= IMM_W.
- IMM_W, 16, immediate field width in bits.
- SHIFT, 2, left-shift amount applied for sel=11; must be < WIDTH.
- CONST_VAL, 4, constant driven for sel=01; truncated to WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- mux_b_control  input  2  source select: 00 regB, 01 constant, 10 extended immediate, 11 extended immediate << SHIFT.
- zext  input  1  1 = zero-extend the immediate; 0 = sign-extend from bit IMM_W-1.
- regB_out  input  WIDTH  register B value.
- imm_in  input  IMM_W  raw immediate field.
- in_valid  input  1  inputs are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- mux_b_out  output  WIDTH  registered operand.
- out_valid  output  1  mux_b_out holds an unconsumed operand.
- out_ready  input  1  consumer accepts mux_b_out this cycle.
- occupancy  output  2  number of held operands, 0..2.

Behaviour:
- Operand selection (combinational, internal):
  - ext = zext ? zero-extended imm_in : sign-extended imm_in, to WIDTH bits.
  - sel 00 gives regB_out.
  - sel 01 gives CONST_VAL[WIDTH-1:0].
  - sel 10 gives ext.
  - sel 11 gives ext << SHIFT, truncated to WIDTH; vacated LSBs are 0 and bits shifted past the MSB are discarded.
- Transfer rules:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Storage:
  - Main register (main_data, main_valid) drives mux_b_out and out_valid.
  - Skid register (skid_data, skid_valid) is internal.
  - in_ready = !skid_valid && reset. It is registered-state-derived, with no combinational path from out_ready.
  - occupancy = main_valid + skid_valid.
- Per-edge update, with in_xfer and out_xfer as defined above:
  - main empty, in_xfer: main <= selected operand; main_valid <= 1.
  - main full, out_xfer, skid full: main <= skid; skid_valid <= 0. No in_xfer is possible in this case.
  - main full, out_xfer, skid empty, in_xfer: main <= selected operand.
  - main full, out_xfer, skid empty, no in_xfer: main_valid <= 0.
  - main full, no out_xfer, in_xfer: skid <= selected operand; skid_valid <= 1. in_ready drops the following cycle.
  - main full, no out_xfer, no in_xfer: all state holds.
- Latency: an operand accepted at edge k appears on mux_b_out with out_valid=1 after edge k when main was empty or draining. Otherwise it is delayed one cycle per stall cycle.
- Ordering: strictly FIFO. The skid entry is always younger than the main entry.
- Stability: while out_valid && !out_ready, mux_b_out is held constant. Input changes while in_ready=0 have no effect.
- Data registers load only on transfer; there is no toggling when idle.
- Reset: while reset=0, regardless of clk:
  - out_valid=0, mux_b_out=0, in_ready=0, occupancy=0.
  - Internal skid_data=0, skid_valid=0.
  - Reset asserted mid-stall discards both held operands.
  - First in_ready=1 is visible in the cycle after reset deasserts; the first acceptance is at the next rising edge.
- Simultaneous in_xfer and out_xfer with occupancy 1: throughput is 1 operand/cycle and occupancy stays 1.

Test Plan:
- Reset then select sweep (WIDTH=32), out_ready=1, one operand per cycle, each appearing 1 cycle after acceptance:
  - sel 00, regB_out=0xDEADBEEF gives 0xDEADBEEF.
  - sel 01 gives 0x00000004.
  - sel 10, zext=0, imm_in=0x8001 gives 0xFFFF8001.
  - sel 11, zext=0, imm_in=0x8001 gives 0xFFFE0004.
- Extension and truncation:
  - sel 10, zext=1, imm_in=0x8001 gives 0x00008001.
  - sel 11, zext=1, imm_in=0xFFFF gives 0x0003FFFC.
  - sel 11, zext=0, imm_in=0x7FFF gives 0x0001FFFC.
- Backpressure:
  - out_ready=0, issue A=0x11 then B=0x22. After the 2nd edge: occupancy=2, in_ready=0, mux_b_out=0x11 stable.
  - Raise out_ready: outputs 0x11 then 0x22 on consecutive cycles, then occupancy=0 and in_ready=1.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with regB_out=1..8. Output 1..8 in order on consecutive cycles, occupancy stays 1, no bubbles.
- Reset mid-stall: occupancy=2, assert reset asynchronously between edges. Required:
  - out_valid=0, mux_b_out=0 and occupancy=0 immediately, before the next clk edge.
  - After deassertion, new operand 0x55 is output alone, with no stale 0x11/0x22.
- Random valid/ready, 1000 cycles, reference FIFO model:
  - Output sequence equals accepted sequence exactly.
  - occupancy never exceeds 2.
  - mux_b_out never changes while out_valid && !out_ready.
